// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared types and defaults for the write-port arbiter
package wb_port_arbiter_pkg;

  localparam int DEF_DEPTH      = 2;
  localparam int DEF_STARVE_MAX = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_MEM_BYP,
    GNT_MEM_FIFO
  } grant_t;

endpackage

// File: rtl/wb_resp_fifo.sv
// rtl/wb_resp_fifo.sv - ordered buffer for memory responses that lose arbitration
module wb_resp_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       slots [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign head    = slots[rd_ptr];

  // Payload storage carries no reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    if (do_push) slots[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter (ALU vs memory), optional WB_FWD_EN forwarding outputs
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        wb_enable,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
`ifdef WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  localparam int         CW         = $clog2(DEPTH) + 1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [CW-1:0] count;
  logic [3:0]    starve_cnt;
  wb_entry_t     head;
  wb_entry_t     sel;
  grant_t        grant;
  logic          push;
  logic          pop;

  always_comb begin
    grant = GNT_NONE;
    if (starve_cnt == STARVE_LIM && alu_valid) grant = GNT_ALU;
    else if (count != '0)                      grant = GNT_MEM_FIFO;
    else if (mem_valid)                        grant = GNT_MEM_BYP;
    else if (alu_valid)                        grant = GNT_ALU;
  end

  always_comb begin
    sel = '{rd: alu_rd, data: alu_data};
    case (grant)
      GNT_MEM_FIFO: sel = head;
      GNT_MEM_BYP:  sel = '{rd: mem_rd, data: mem_data};
      default:      sel = '{rd: alu_rd, data: alu_data};
    endcase
  end

  // A response that does not bypass straight to the output must be buffered.
  assign push      = mem_valid && (grant != GNT_MEM_BYP);
  assign pop       = (grant == GNT_MEM_FIFO);
  assign alu_ready = reset && (grant == GNT_ALU);
  assign mem_ready = (count < CW'(DEPTH));
  assign busy      = (count != '0) || wb_enable;

  wb_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry ('{rd: mem_rd, data: mem_data}),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt <= '0;
      wb_enable  <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
`ifdef WB_FWD_EN
      fwd_valid  <= 1'b0;
      fwd_rd     <= '0;
      fwd_data   <= '0;
`endif
    end else begin
      if (!alu_valid || grant == GNT_ALU)  starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM)   starve_cnt <= starve_cnt + 4'd1;
      // rd==0 entries are consumed but never strobe the register file.
      wb_enable <= (grant != GNT_NONE) && (sel.rd != 5'd0);
      if (grant != GNT_NONE) begin
        wb_rd   <= sel.rd;
        wb_data <= sel.data;
      end
`ifdef WB_FWD_EN
      fwd_valid <= (grant != GNT_NONE) && (sel.rd != 5'd0);
      if (grant != GNT_NONE) begin
        fwd_rd   <= sel.rd;
        fwd_data <= sel.data;
      end
`endif
    end
  end

  assert property (@(posedge clock) disable iff (!reset) mem_valid |-> mem_ready);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - table-driven bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, wb_rd;
  logic [31:0] alu_data, mem_data, wb_data;
  logic        wb_enable, busy;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .wb_enable (wb_enable),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .busy      (busy)
`ifdef WB_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        ar;
    logic        mr;
    logic        wen;
    logic        chk;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        bsy;
  } row_t;

  row_t rows[$];
  int   total  = 0;
  int   passed = 0;

  function automatic void add(input int rst, input int av, input int ard, input int adata,
                              input int mv, input int mrd, input int mdata,
                              input int ar, input int mr, input int wen, input int chk,
                              input int wrd, input int wdata, input int bsy);
    row_t r;
    r.rst = 1'(rst);   r.av = 1'(av);   r.ard = 5'(ard);  r.adata = 32'(adata);
    r.mv  = 1'(mv);    r.mrd = 5'(mrd); r.mdata = 32'(mdata);
    r.ar  = 1'(ar);    r.mr = 1'(mr);   r.wen = 1'(wen);  r.chk = 1'(chk);
    r.wrd = 5'(wrd);   r.wdata = 32'(wdata); r.bsy = 1'(bsy);
    rows.push_back(r);
  endfunction

  // Memory streams m0..m9 with ALU held high: four bypass wins, forced ALU win
  // (m4 buffered), four FIFO wins with push, forced ALU win (m9 buffered) -> count 2.
  function automatic void fill(input int b);
    for (int k = 0; k < 10; k++) begin
      int ard = (k < 5) ? 13 : 14;
      int ad  = b + 'h80 + ((k < 5) ? 0 : 1);
      int prv = (k > 4) ? k - 1 : k;
      if (k == 4 || k == 9) add(1, 1, ard, ad, 1, 16 + k, b + k, 1, 1, 1, 1, ard, ad, 1);
      else                  add(1, 1, ard, ad, 1, 16 + k, b + k, 0, 1, 1, 1, 16 + prv, b + prv, 1);
    end
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s row %0d: got %0h, expected %0h", name, idx, act, exp);
    else passed++;
  endtask

  initial begin
    reset = 1'b0; alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_wb_enable", -1, 32'(wb_enable), 0);
    check("rst_wb_rd",     -1, 32'(wb_rd), 0);
    check("rst_wb_data",   -1, wb_data, 0);
    check("rst_busy",      -1, 32'(busy), 0);
    check("rst_alu_ready", -1, 32'(alu_ready), 0);
    check("rst_mem_ready", -1, 32'(mem_ready), 1);

    // lone ALU, lone mem bypass, idle, contention, held ALU, rd==0, idle
    add(1, 1, 5, 'h11, 0, 0, 0,      1, 1, 1, 1, 5, 'h11, 1);
    add(1, 0, 0, 0, 1, 6, 'h22,      0, 1, 1, 1, 6, 'h22, 1);
    add(1, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 3, 'hA, 1, 4, 'hB,     0, 1, 1, 1, 4, 'hB, 1);
    add(1, 1, 3, 'hA, 0, 0, 0,       1, 1, 1, 1, 3, 'hA, 1);
    add(1, 1, 0, 'hFFFF, 0, 0, 0,    1, 1, 0, 1, 0, 'hFFFF, 0);
    add(1, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 0, 0);
    // starvation: four mem wins, ALU forced on the fifth grant, buffered mem drains
    for (int k = 0; k < 4; k++)
      add(1, 1, 7, 'h77, 1, 8 + k, 'h80 + 16 * k, 0, 1, 1, 1, 8 + k, 'h80 + 16 * k, 1);
    add(1, 1, 7, 'h77, 1, 12, 'hC0,  1, 1, 1, 1, 7, 'h77, 1);
    add(1, 0, 0, 0, 0, 0, 0,         0, 1, 1, 1, 12, 'hC0, 1);
    // with ALU granted last, contention now goes to memory again
    add(1, 1, 2, 'h55, 1, 1, 'h66,   0, 1, 1, 1, 1, 'h66, 1);
    add(1, 1, 2, 'h55, 0, 0, 0,      1, 1, 1, 1, 2, 'h55, 1);
    // FIFO full, conservative mem_ready during pop, in-order drain across wrap
    fill('h100);
    add(1, 0, 0, 0, 0, 0, 0,         0, 0, 1, 1, 24, 'h108, 1);
    add(1, 0, 0, 0, 0, 0, 0,         0, 1, 1, 1, 25, 'h109, 1);
    add(1, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 0, 0);
    // refill to two entries then reset: buffered responses must never be written
    fill('h200);
    add(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 0, 0);

    foreach (rows[i]) begin
      @(negedge clock);
      reset     = rows[i].rst;
      alu_valid = rows[i].av;  alu_rd = rows[i].ard; alu_data = rows[i].adata;
      mem_valid = rows[i].mv;  mem_rd = rows[i].mrd; mem_data = rows[i].mdata;
      #1;
      check("alu_ready", i, 32'(alu_ready), 32'(rows[i].ar));
      check("mem_ready", i, 32'(mem_ready), 32'(rows[i].mr));
      @(posedge clock);
      #1;
      check("wb_enable", i, 32'(wb_enable), 32'(rows[i].wen));
      check("busy",      i, 32'(busy), 32'(rows[i].bsy));
      if (rows[i].chk) begin
        check("wb_rd",   i, 32'(wb_rd), 32'(rows[i].wrd));
        check("wb_data", i, wb_data, rows[i].wdata);
      end
    end

    @(negedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
